// File: rtl/sequenciador_de_instrucoes.sv
// Instruction sequencer: word FIFO, 4-step counter, LDI immediate fetch.
// Ports:
//   clock, resetn           clock; asynchronous active-low reset
//   run                     allows a new instruction to start
//   instr_in, instr_valid   source word and its valid strobe
//   instr_ready             FIFO has room this cycle
//   counter                 step: 00 fetch, 01 decode, 10 execute, 11 writeback
//   iin, imm                current instruction and immediate registers
//   busy, stall             step != 00; decode waiting for an LDI immediate
module sequenciador_de_instrucoes #(
   parameter int         DEPTH  = 4,
   parameter logic [2:0] LDI_OP = 3'b101
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       run,
   input  logic [8:0] instr_in,
   input  logic       instr_valid,
   output logic       instr_ready,
   output logic [1:0] counter,
   output logic [8:0] iin,
   output logic [8:0] imm,
   output logic       busy,
   output logic       stall
);

   localparam int           AW   = $clog2(DEPTH);
   localparam logic [AW:0]  FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_FETCH  = 2'b00,
      S_DECODE = 2'b01,
      S_EXEC   = 2'b10,
      S_WB     = 2'b11
   } state_t;

   state_t state_q, state_d;

   logic [8:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          push, pop, empty;
   logic          load_iin, load_imm;
   logic          is_ldi;
   logic [8:0]    head;

   assign empty       = (count == '0);
   assign instr_ready = (count != FULL);
   // a full FIFO refuses input even if a pop frees a slot this cycle
   assign push        = instr_valid && instr_ready;
   assign head        = mem[rd_ptr];
   assign is_ldi      = (iin[8:6] == LDI_OP);

   // storage needs no reset: only occupied slots are ever read
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= instr_in;
      end
   end

   // pointers are AW bits wide, so they wrap modulo DEPTH
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_FETCH;
         iin     <= '0;
         imm     <= '0;
      end else begin
         state_q <= state_d;
         if (load_iin) begin
            iin <= head;
         end
         if (load_imm) begin
            imm <= head;
         end
      end
   end

   // pop decisions use registered occupancy, so a word pushed
   // on this edge is never visible to the FSM until the next one
   always_comb begin
      state_d  = state_q;
      pop      = 1'b0;
      load_iin = 1'b0;
      load_imm = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            if (run && !empty) begin
               pop      = 1'b1;
               load_iin = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            if (is_ldi) begin
               if (!empty) begin
                  pop      = 1'b1;
                  load_imm = 1'b1;
                  state_d  = S_EXEC;
               end
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d = S_WB;
         end
         S_WB: begin
            state_d = S_FETCH;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   assign counter = state_q;
   assign busy    = (state_q != S_FETCH);
   assign stall   = (state_q == S_DECODE) && is_ldi && empty;

endmodule

// File: tb/tb_sequenciador_de_instrucoes.sv
// Directed bench for sequenciador_de_instrucoes.
// Expected words are queued by stimulus and popped by the monitor.
module tb_sequenciador_de_instrucoes;

   logic       clock;
   logic       resetn;
   logic       run;
   logic [8:0] instr_in;
   logic       instr_valid;
   logic       instr_ready;
   logic [1:0] counter;
   logic [8:0] iin;
   logic [8:0] imm;
   logic       busy;
   logic       stall;

   sequenciador_de_instrucoes dut (
      .clock       (clock),
      .resetn      (resetn),
      .run         (run),
      .instr_in    (instr_in),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .counter     (counter),
      .iin         (iin),
      .imm         (imm),
      .busy        (busy),
      .stall       (stall)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [8:0] exp_iin [$];
   logic [8:0] exp_imm [$];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [8:0] act,
                      input logic [8:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, expv, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_counter(input logic [1:0] v, input string name);
      for (int k = 0; k < 20; k++) begin
         tick();
         if (counter == v) break;
      end
      chk(name, {7'd0, counter}, {7'd0, v});
   endtask

   task automatic push_word(input logic [8:0] w);
      instr_in    = w;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
   endtask

   // monitor: step sequencing, register stability, scoreboard pops
   logic [1:0] prev_c;
   logic [8:0] prev_iin;
   logic [8:0] prev_imm;

   always @(negedge clock) begin
      if (!resetn) begin
         prev_c   = 2'b00;
         prev_iin = '0;
         prev_imm = '0;
      end else begin
         chk("busy", {8'd0, busy}, {8'd0, (counter != 2'b00)});
         case (prev_c)
            2'b00: begin
               if (counter == 2'b01) begin
                  if (exp_iin.size() == 0) begin
                     chk("unexpected_start", iin, 9'h1FF);
                  end else begin
                     chk("iin", iin, exp_iin.pop_front());
                  end
               end else begin
                  chk("fetch_step", {7'd0, counter}, 9'd0);
               end
            end
            2'b01: begin
               if (prev_iin[8:6] != 3'b101) begin
                  chk("decode_step", {7'd0, counter}, 9'd2);
               end else if (counter == 2'b10) begin
                  if (exp_imm.size() == 0) begin
                     chk("unexpected_imm", imm, 9'h1FF);
                  end else begin
                     chk("imm", imm, exp_imm.pop_front());
                  end
               end else begin
                  chk("ldi_hold", {7'd0, counter}, 9'd1);
               end
            end
            2'b10: chk("exec_step", {7'd0, counter}, 9'd3);
            default: chk("wb_step", {7'd0, counter}, 9'd0);
         endcase
         if (prev_c != 2'b00) begin
            chk("iin_stable", iin, prev_iin);
         end
         if (!(prev_c == 2'b01 && counter == 2'b10 &&
               prev_iin[8:6] == 3'b101)) begin
            chk("imm_stable", imm, prev_imm);
         end
         prev_c   = counter;
         prev_iin = iin;
         prev_imm = imm;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout");
      $fatal(1, "watchdog");
   end

   logic [8:0] w2 [5];

   initial begin
      resetn      = 1'b0;
      run         = 1'b0;
      instr_in    = '0;
      instr_valid = 1'b0;
      w2 = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h055};

      // reset state
      #2;
      chk("rst_counter", {7'd0, counter}, 9'd0);
      chk("rst_iin", iin, 9'd0);
      chk("rst_imm", imm, 9'd0);
      chk("rst_busy", {8'd0, busy}, 9'd0);
      chk("rst_stall", {8'd0, stall}, 9'd0);
      @(posedge clock);
      #2 resetn = 1'b1;
      #1 chk("rst_ready", {8'd0, instr_ready}, 9'd1);

      // single ADD r1,r2
      run = 1'b1;
      exp_iin.push_back(9'h00A);
      push_word(9'h00A);
      wait_counter(2'b01, "t1_dec");
      chk("t1_busy1", {8'd0, busy}, 9'd1);
      tick();
      chk("t1_exec", {7'd0, counter}, 9'd2);
      chk("t1_busy2", {8'd0, busy}, 9'd1);
      tick();
      chk("t1_wb", {7'd0, counter}, 9'd3);
      chk("t1_busy3", {8'd0, busy}, 9'd1);
      tick();
      chk("t1_fetch", {7'd0, counter}, 9'd0);
      chk("t1_busy0", {8'd0, busy}, 9'd0);
      chk("t1_imm", imm, 9'd0);
      run = 1'b0;

      // fill to full, fifth word dropped
      instr_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         instr_in = w2[i];
         chk("t2_ready", {8'd0, instr_ready}, {8'd0, (i < 4)});
         if (i < 4) exp_iin.push_back(w2[i]);
         tick();
      end
      instr_valid = 1'b0;
      chk("t2_full", {8'd0, instr_ready}, 9'd0);
      run = 1'b1;
      wait_counter(2'b01, "t2_first");
      for (int j = 0; j < 3; j++) begin
         repeat (4) tick();
         chk("t2_spacing", {7'd0, counter}, 9'd1);
      end
      wait_counter(2'b00, "t2_done");

      // LDI waiting for its immediate
      exp_iin.push_back(9'h158);
      exp_imm.push_back(9'h1F5);
      push_word(9'h158);
      wait_counter(2'b01, "t3_dec");
      chk("t3_stall0", {8'd0, stall}, 9'd1);
      for (int j = 0; j < 3; j++) begin
         tick();
         chk("t3_hold", {7'd0, counter}, 9'd1);
         chk("t3_stall", {8'd0, stall}, 9'd1);
      end
      push_word(9'h1F5);
      chk("t3_nobypass", {7'd0, counter}, 9'd1);
      chk("t3_unstall", {8'd0, stall}, 9'd0);
      tick();
      chk("t3_exec", {7'd0, counter}, 9'd2);
      chk("t3_imm", imm, 9'h1F5);
      tick();
      chk("t3_wb", {7'd0, counter}, 9'd3);
      tick();
      chk("t3_fetch", {7'd0, counter}, 9'd0);

      // simultaneous push and pop at occupancy 1
      run = 1'b0;
      exp_iin.push_back(9'h00B);
      push_word(9'h00B);
      chk("t4_idle", {7'd0, counter}, 9'd0);
      run = 1'b1;
      exp_iin.push_back(9'h019);
      push_word(9'h019);
      chk("t4_dec", {7'd0, counter}, 9'd1);
      chk("t4_ready", {8'd0, instr_ready}, 9'd1);
      repeat (4) tick();
      chk("t4_next", {7'd0, counter}, 9'd1);
      chk("t4_iin", iin, 9'h019);
      wait_counter(2'b00, "t4_done");
      for (int j = 0; j < 3; j++) begin
         tick();
         chk("t4_empty_idle", {7'd0, counter}, 9'd0);
      end

      // asynchronous reset mid-instruction with words queued
      run = 1'b0;
      exp_iin.push_back(9'h0A1);
      push_word(9'h0A1);
      push_word(9'h0D2);
      push_word(9'h0E3);
      push_word(9'h0F4);
      run = 1'b1;
      wait_counter(2'b10, "t5_exec");
      #1 resetn = 1'b0;
      #1;
      chk("t5_counter", {7'd0, counter}, 9'd0);
      chk("t5_iin", iin, 9'd0);
      chk("t5_imm", imm, 9'd0);
      chk("t5_busy", {8'd0, busy}, 9'd0);
      chk("t5_ready", {8'd0, instr_ready}, 9'd1);
      @(posedge clock);
      #2 resetn = 1'b1;
      for (int j = 0; j < 6; j++) begin
         tick();
         chk("t5_flushed", {7'd0, counter}, 9'd0);
      end

      // run dropped during execute
      run = 1'b0;
      exp_iin.push_back(9'h062);
      push_word(9'h062);
      push_word(9'h073);
      run = 1'b1;
      wait_counter(2'b10, "t6_exec");
      run = 1'b0;
      tick();
      chk("t6_wb", {7'd0, counter}, 9'd3);
      tick();
      chk("t6_fetch", {7'd0, counter}, 9'd0);
      for (int j = 0; j < 5; j++) begin
         tick();
         chk("t6_hold", {7'd0, counter}, 9'd0);
         chk("t6_busy", {8'd0, busy}, 9'd0);
      end
      exp_iin.push_back(9'h073);
      run = 1'b1;
      wait_counter(2'b01, "t6_resume");
      wait_counter(2'b00, "t6_done");

      chk("iin_queue_left", 9'(exp_iin.size()), 9'd0);
      chk("imm_queue_left", 9'(exp_imm.size()), 9'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
